// File: rtl/cont_4bits.sv
// Cascadable binary up-counter with count enable and combinational terminal count.
// TC of one stage drives the enable of the next to build wider counters.
module cont_4bits #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reseta_n,
  input  logic             enable,
  output logic [WIDTH-1:0] Q,
  output logic             TC
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Carry out of the MSB is dropped, so all-ones wraps to zero.
  always_comb begin
    q_d = q_q;
    if (enable) begin
      q_d = q_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reseta_n) begin
    if (!reseta_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign TC = enable & (q_q == ALL_ONES);

endmodule

// File: tb/tb_cont_4bits.sv
// Directed and random-enable checks of cont_4bits: reset, stepping, wrap, TC gating,
// asynchronous reset mid-count.
module tb_cont_4bits;

  logic       clk;
  logic       reseta_n;
  logic       enable;
  logic [3:0] Q;
  logic       TC;

  int compared;
  int mismatched;

  cont_4bits #(.WIDTH(4)) dut (
    .clk      (clk),
    .reseta_n (reseta_n),
    .enable   (enable),
    .Q        (Q),
    .TC       (TC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_q(input string tag, input logic [3:0] exp);
    compared++;
    assert (Q === exp) else begin
      mismatched++;
      $error("FAIL %s: Q observed %0d expected %0d", tag, Q, exp);
    end
  endtask

  task automatic chk_tc(input string tag, input logic exp);
    compared++;
    assert (TC === exp) else begin
      mismatched++;
      $error("FAIL %s: TC observed %b expected %b", tag, TC, exp);
    end
  endtask

  task automatic async_reset();
    reseta_n = 1'b0;
    #1;
    chk_q("reset_assert_q", 4'd0);
    chk_tc("reset_assert_tc", 1'b0);
    #1;
    reseta_n = 1'b1;
  endtask

  logic [3:0] q_m;
  logic [3:0] exp_q;

  initial begin
    compared   = 0;
    mismatched = 0;
    reseta_n   = 1'b1;
    enable     = 1'b0;

    // Power-up reset: 10 ns pulse, released between edges.
    #2;
    reseta_n = 1'b0;
    #1;
    chk_q("por_q", 4'd0);
    chk_tc("por_tc", 1'b0);
    #9;
    reseta_n = 1'b1;
    tick();
    chk_q("por_hold1", 4'd0);
    tick();
    chk_q("por_hold2", 4'd0);
    chk_tc("por_hold_tc", 1'b0);

    // Single-step.
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk_q("step1", 4'd1);
    tick();
    chk_q("step1_hold", 4'd1);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk_q("step2", 4'd2);
    tick();
    chk_q("step2_hold", 4'd2);

    // Full wrap from zero.
    async_reset();
    enable = 1'b1;
    exp_q = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      chk_tc("wrap_tc_pre", (exp_q == 4'd15));
      tick();
      exp_q = exp_q + 4'd1;
      chk_q("wrap_q", exp_q);
    end
    chk_q("wrap_end_q", 4'd0);
    chk_tc("wrap_end_tc", 1'b0);

    // Count up to 15, then gate TC with enable.
    for (int i = 0; i < 15; i++) tick();
    chk_q("to15_q", 4'd15);
    chk_tc("to15_tc", 1'b1);
    enable = 1'b0;
    #1;
    chk_tc("gate_tc", 1'b0);
    tick();
    chk_q("gate_hold1", 4'd15);
    tick();
    chk_q("gate_hold2", 4'd15);
    chk_tc("gate_tc2", 1'b0);

    // Asynchronous reset mid-count at Q=9.
    async_reset();
    enable = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    chk_q("mid_q9", 4'd9);
    #1;
    reseta_n = 1'b0;
    #1;
    chk_q("mid_reset_q", 4'd0);
    chk_tc("mid_reset_tc", 1'b0);
    #2;
    reseta_n = 1'b1;
    tick();
    chk_q("mid_resume1", 4'd1);
    tick();
    chk_q("mid_resume2", 4'd2);
    tick();
    chk_q("mid_resume3", 4'd3);

    // Random enable against a reference model.
    q_m = 4'd3;
    for (int i = 0; i < 30; i++) begin
      enable = 1'($urandom_range(0, 1));
      #1;
      chk_tc("rand_tc", enable & (q_m == 4'd15));
      tick();
      q_m = q_m + {3'd0, enable};
      chk_q("rand_q", q_m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
